// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-requester multiplier front end.
package mul_arb_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 20;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that was not granted last wins.
// last = 0 means requester 0 was granted most recently, last = 1 means requester 1.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant from the request pair and the last-grant pointer
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/mul_arb_ctrl.sv
// Arbitrates two operand requesters onto one shared multiplier, waits for the
// multiplier with a bounded timeout and presents the result with its owner id.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Requester ready is combinational and only offered in IDLE; the response
// side holds rsp_* stable while rsp_valid_o is high until rsp_ready_i is seen.
module mul_arb_ctrl
  import mul_arb_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req0_valid_i,
  input  logic [W-1:0] req0_a_i,
  input  logic [W-1:0] req0_b_i,
  output logic         req0_ready_o,
  input  logic         req1_valid_i,
  input  logic [W-1:0] req1_a_i,
  input  logic [W-1:0] req1_b_i,
  output logic         req1_ready_o,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_id_o,
  output logic [W-1:0] rsp_y_o,
  output logic         rsp_err_o,
  output logic         mul_start_o,
  output logic [W-1:0] mul_a_o,
  output logic [W-1:0] mul_b_o,
  input  logic         mul_done_i,
  input  logic [W-1:0] mul_y_i,
  output logic         busy_o,
  output state_t       state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     op_a_q;
  logic [W-1:0]     op_b_q;
  logic             id_q;
  logic [W-1:0]     y_q;
  logic             err_q;
  logic [1:0]       gnt;
  logic             offer;

  rr_arb2 u_arb (
    .req  ({req1_valid_i, req0_valid_i}),
    .last (last_q),
    .gnt  (gnt)
  );

  // Ready is offered only while idle and never while reset is held
  always_comb begin
    offer        = (state_q == S_IDLE) && rst_ni;
    req0_ready_o = offer & gnt[0];
    req1_ready_o = offer & gnt[1];
  end

  // Controller FSM with operand, id and result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      id_q    <= 1'b0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // In IDLE a set grant bit is exactly valid && ready for that requester
          if (gnt[1]) begin
            op_a_q  <= req1_a_i;
            op_b_q  <= req1_b_i;
            id_q    <= 1'b1;
            last_q  <= 1'b1;
            state_q <= S_ISSUE;
          end else if (gnt[0]) begin
            op_a_q  <= req0_a_i;
            op_b_q  <= req0_b_i;
            id_q    <= 1'b0;
            last_q  <= 1'b0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done in the final timeout cycle still counts as success
          if (mul_done_i) begin
            y_q     <= mul_y_i;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            y_q     <= '0;
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded straight from registers
  always_comb begin
    rsp_valid_o = (state_q == S_RESP);
    mul_start_o = (state_q == S_ISSUE);
    busy_o      = (state_q != S_IDLE);
    rsp_id_o    = id_q;
    rsp_y_o     = y_q;
    rsp_err_o   = err_q;
    mul_a_o     = op_a_q;
    mul_b_o     = op_b_q;
    state_o     = state_q;
  end

endmodule

// File: doc/mul_arb_ctrl.md
MUL_ARB_CTRL -- requirements
Module: mul_arb_ctrl

Interface
REQ-001 Parameter W, default 16: operand and product width in bits.
REQ-002 Parameter TIMEOUT, default 20: maximum number of WAIT cycles before the transaction is aborted; legal range is 2 to 255.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 req0_valid_i, req1_valid_i  in  1  requester n has an operand pair pending.
REQ-006 req0_a_i, req0_b_i, req1_a_i, req1_b_i  in  W  operands of requester n.
REQ-007 req0_ready_o, req1_ready_o  out  1  requester n's operands are accepted this cycle.
REQ-008 rsp_valid_o  out  1  a result is presented.
REQ-009 rsp_ready_i  in  1  the consumer takes the result.
REQ-010 rsp_id_o  out  1  index of the requester that owns the result.
REQ-011 rsp_y_o  out  W  low W bits of a*b.
REQ-012 rsp_err_o  out  1  the transaction timed out.
REQ-013 mul_start_o  out  1  one-cycle start pulse to the shared multiplier.
REQ-014 mul_a_o, mul_b_o  out  W  multiplier operands.
REQ-015 mul_done_i  in  1  multiplier finished.
REQ-016 mul_y_i  in  W  multiplier result, valid while mul_done_i=1.
REQ-017 busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE: one valid requester is granted; if both are valid, the requester other than the last granted one wins (round-robin).
REQ-020 reqN_ready_o SHALL be high only in IDLE and only for the granted requester; it is combinational from the valid inputs and the pointer.
REQ-021 On valid&&ready: latch operands and id, update the last-grant pointer, go to ISSUE.
REQ-022 ISSUE lasts exactly one cycle; mul_start_o=1; next state is WAIT with the timeout counter cleared to 0.
REQ-023 mul_a_o and mul_b_o SHALL hold the latched operands, stable from ISSUE until the next grant.
REQ-024 WAIT behaviour:
- mul_done_i=1: capture mul_y_i into rsp_y_o, set rsp_err_o=0, go to RESP.
- Otherwise, when the counter equals TIMEOUT-1: set rsp_y_o=0, rsp_err_o=1, go to RESP.
- Otherwise: increment the counter.
REQ-025 When mul_done_i and the timeout occur in the same cycle, done wins and rsp_err_o=0.
REQ-026 mul_done_i SHALL be ignored outside WAIT.
REQ-027 In RESP: rsp_valid_o=1, and rsp_y_o, rsp_id_o and rsp_err_o are held stable until rsp_ready_i=1, then the FSM returns to IDLE.
REQ-028 No new grant occurs in the RESP-to-IDLE transition cycle; the earliest next grant is the following cycle.
REQ-029 Latency: accept at cycle t, start at t+1, done at t+1+k gives rsp_valid_o at t+2+k, for k>=1.
REQ-030 Requester valid inputs that drop without a handshake SHALL have no effect.

Reset
REQ-031 rst_ni=0 forces, asynchronously: state=IDLE, last-grant pointer=1 (so req0 wins the first tie), counter=0, all outputs 0.
REQ-032 Reset mid-operation abandons the transaction; no response is ever produced for it.
REQ-033 After rst_ni is released, arbitration starts on the first clock edge.

Structure
REQ-034 Package mul_arb_pkg SHALL hold the FSM state enum, the W/TIMEOUT defaults and the counter width constant (8).
REQ-035 The 2-way round-robin grant logic SHALL be sub-module rr_arb2 (inputs: req[1:0], last; output: one-hot gnt[1:0]); all other logic stays in mul_arb_ctrl.

Verification
REQ-036 req0 only, a=3, b=5; multiplier done 17 cycles after start with y=15 -> rsp_valid_o, rsp_id_o=0, rsp_y_o=15, rsp_err_o=0, rsp_valid_o 19 cycles after accept.
REQ-037 req0 and req1 valid together after reset, repeatedly -> grants alternate 0,1,0,1; each result carries the correct id.
REQ-038 a=16'hFFFF, b=2, y=16'hFFFE; rsp_ready_i held low for 5 cycles -> result stable for all 5 cycles, FSM returns to IDLE one cycle after rsp_ready_i goes high.
REQ-039 mul_done_i never asserts, TIMEOUT=20 -> RESP after 20 WAIT cycles with rsp_err_o=1, rsp_y_o=0.
REQ-040 mul_done_i asserted on the cycle the counter equals 19 -> rsp_err_o=0.
REQ-041 rst_ni pulsed low during WAIT -> outputs 0 immediately; no rsp_valid_o; a following req1 is granted normally.
